// File: rtl/neuron_pkg.sv
// rtl/neuron_pkg.sv - shared types and arithmetic helpers for the sequential neuron
package neuron_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        ACT  = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam logic ACT_STEP = 1'b0;
    localparam logic ACT_RELU = 1'b1;

    // Add two sign-extended values and clamp to the signed range of acc_w bits.
    function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                   input logic signed [63:0] b,
                                                   input int acc_w);
        logic signed [63:0] sum;
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sum = a + b;
        hi  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        if (sum > hi) return hi;
        if (sum < lo) return lo;
        return sum;
    endfunction

    // Clamp to [0, 2^(out_w-1)-1].
    function automatic logic signed [63:0] relu_clamp(input logic signed [63:0] acc,
                                                      input int out_w);
        logic signed [63:0] hi;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        if (acc < 64'sd0) return 64'sd0;
        if (acc > hi) return hi;
        return acc;
    endfunction

endpackage

// File: rtl/neuron_mac_unit.sv
// rtl/neuron_mac_unit.sv - signed multiply/accumulate datapath (NEURON_SAT_EN selects saturation)
import neuron_pkg::*;

module neuron_mac_unit #(
    parameter int WIDTH     = 8,
    parameter int ACC_WIDTH = 18
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        load,
    input  logic signed [WIDTH-1:0]     load_val,
    input  logic                        en,
    input  logic signed [WIDTH-1:0]     w,
    input  logic signed [WIDTH-1:0]     x,
    output logic signed [ACC_WIDTH-1:0] acc
);

    logic signed [2*WIDTH-1:0]   prod;
    logic signed [ACC_WIDTH-1:0] prod_ext;
    logic signed [ACC_WIDTH-1:0] acc_next;

    // Full-precision product, then sign-extended to the accumulator width.
    assign prod     = (2*WIDTH)'(w) * (2*WIDTH)'(x);
    assign prod_ext = ACC_WIDTH'(prod);

`ifdef NEURON_SAT_EN
    logic signed [63:0] full_sum;
    logic signed [63:0] sat_sum;
    logic               sat_seen;

    assign full_sum = 64'(acc) + 64'(prod_ext);
    assign sat_sum  = sat_add(64'(acc), 64'(prod_ext), ACC_WIDTH);
    assign acc_next = ACC_WIDTH'(sat_sum);

    // Sticky record that some update clipped; cleared when a new evaluation loads.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sat_seen <= 1'b0;
        end else if (load) begin
            sat_seen <= 1'b0;
        end else if (en && (sat_sum != full_sum)) begin
            sat_seen <= 1'b1;
        end
    end
`else
    assign acc_next = acc + prod_ext;
`endif

    // Accumulator: bias preload on start, one product per accepted beat.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (load) begin
            acc <= ACC_WIDTH'(load_val);
        end else if (en) begin
            acc <= acc_next;
        end
    end

endmodule

// File: rtl/neuron_seq_nbits.sv
// rtl/neuron_seq_nbits.sv - framed sequential neuron top; optional NEURON_SAT_EN saturating acc
import neuron_pkg::*;

module neuron_seq_nbits #(
    parameter int WIDTH     = 8,
    parameter int NUM_IN    = 4,
    parameter int ACC_WIDTH = 2*WIDTH + $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic signed [WIDTH-1:0] bias,
    input  logic                    act_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic signed [WIDTH-1:0] W,
    input  logic signed [WIDTH-1:0] X,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic signed [WIDTH-1:0] Out,
    output logic                    busy
);

    localparam int CNT_W = $clog2(NUM_IN + 1);

    state_t                      state;
    logic [CNT_W-1:0]            count;
    logic                        act_mode;
    logic signed [ACC_WIDTH-1:0] acc;
    logic                        load;
    logic                        beat;
    logic signed [WIDTH-1:0]     step_val;
    logic signed [WIDTH-1:0]     relu_val;

    assign load = (state == IDLE) && start;
    assign beat = in_valid && in_ready;

    neuron_mac_unit #(
        .WIDTH     (WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_mac (
        .clk      (clk),
        .rst      (rst),
        .load     (load),
        .load_val (bias),
        .en       (beat),
        .w        (W),
        .x        (X),
        .acc      (acc)
    );

    // Both activation candidates, selected in ACT by the mode latched at start.
    always_comb begin
        step_val = '0;
        relu_val = WIDTH'(relu_clamp(64'(acc), WIDTH));
        if (acc > 0) begin
            step_val = WIDTH'(1);
        end
    end

    // Control FSM with registered handshake, busy and result outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            count     <= '0;
            act_mode  <= ACT_STEP;
            Out       <= '0;
            out_valid <= 1'b0;
            in_ready  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        act_mode <= act_sel;
                        count    <= '0;
                        in_ready <= 1'b1;
                        busy     <= 1'b1;
                        state    <= ACC;
                    end
                end
                ACC: begin
                    if (beat) begin
                        count <= count + 1'b1;
                        if (count == CNT_W'(NUM_IN - 1)) begin
                            in_ready <= 1'b0;
                            state    <= ACT;
                        end
                    end
                end
                ACT: begin
                    Out       <= (act_mode == ACT_RELU) ? relu_val : step_val;
                    out_valid <= 1'b1;
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        busy      <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
